// File: rtl/r2n_buffer_pkg.sv
// Shared types and helpers for the ready-to-normal row buffer.
package r2n_buffer_pkg;

  // Controller states: IDLE waits for en, FILL collects one row group, DRAIN replays it row by row.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } r2n_state_e;

  // Counter width for a modulo-n counter; a single-value counter still gets one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/r2n_row_store.sv
// Row store for one group: block-scatter write of a full beat, combinational row read.
module r2n_row_store
  import r2n_buffer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4,
  parameter int COL        = 64,
  parameter int NUM_CORES  = 4,
  localparam int DEPTH     = BLOCK_SIZE * NUM_CORES,
  localparam int BEATS     = COL / BLOCK_SIZE,
  localparam int BEAT_W    = cnt_width(BEATS),
  localparam int ROW_W     = cnt_width(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic [BEAT_W-1:0]                     wr_beat,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] wr_data,
  input  logic [ROW_W-1:0]                      rd_row,
  output logic [WIDTH*COL-1:0]                  rd_data
);

  localparam int CHUNK_W = WIDTH * CHUNK_SIZE;

  logic [WIDTH*COL-1:0] store_q [DEPTH];
  logic [WIDTH*COL-1:0] store_d [DEPTH];

  // Scatter each core's block into its BLOCK_SIZE rows at the columns owned by the current beat.
  // The beat index is decoded against constants so every element lands on a fixed slice.
  always_comb begin
    store_d = store_q;
    if (wr_en) begin
      for (int b = 0; b < BEATS; b++) begin
        if (wr_beat == BEAT_W'(b)) begin
          for (int c = 0; c < NUM_CORES; c++) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
              for (int k = 0; k < BLOCK_SIZE; k++) begin
                store_d[c*BLOCK_SIZE + r][(COL-1-(b*BLOCK_SIZE + k))*WIDTH +: WIDTH] =
                  wr_data[(NUM_CORES-1-c)*CHUNK_W + (CHUNK_SIZE-1-(r*BLOCK_SIZE + k))*WIDTH +: WIDTH];
              end
            end
          end
        end
      end
    end
  end

  // Data storage only; every row is fully rewritten before it is read, so no reset is needed.
  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

  assign rd_data = store_q[rd_row];

endmodule

// File: rtl/r2n_buffer.sv
// Ready-to-normal buffer: collects one row group of result blocks and replays it as full rows.
module r2n_buffer
  import r2n_buffer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int BLOCK_SIZE = 2,
  parameter int CHUNK_SIZE = 4,
  parameter int ROW        = 64,
  parameter int COL        = 64,
  parameter int NUM_CORES  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_r2n_buffer,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH*COL-1:0]                  out_r2n_buffer,
  output logic                                  frame_done
);

  localparam int GRP_DEPTH = BLOCK_SIZE * NUM_CORES;
  localparam int BEATS     = COL / BLOCK_SIZE;
  localparam int GROUPS    = ROW / GRP_DEPTH;
  localparam int BEAT_W    = cnt_width(BEATS);
  localparam int ROW_W     = cnt_width(GRP_DEPTH);
  localparam int GRP_W     = cnt_width(GROUPS);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(GRP_DEPTH - 1);
  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(GROUPS - 1);

  if (CHUNK_SIZE != BLOCK_SIZE * BLOCK_SIZE) begin : g_chk_chunk
    $error("r2n_buffer: CHUNK_SIZE must equal BLOCK_SIZE*BLOCK_SIZE");
  end
  if ((ROW % GRP_DEPTH) != 0) begin : g_chk_row
    $error("r2n_buffer: ROW must be a multiple of BLOCK_SIZE*NUM_CORES");
  end
  if ((COL % BLOCK_SIZE) != 0) begin : g_chk_col
    $error("r2n_buffer: COL must be a multiple of BLOCK_SIZE");
  end
  if (FRAC_WIDTH >= WIDTH) begin : g_chk_frac
    $error("r2n_buffer: FRAC_WIDTH must be smaller than WIDTH");
  end

  r2n_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
  logic [GRP_W-1:0]  grp_cnt_q, grp_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_en;
  logic [WIDTH*COL-1:0] rd_data;

  r2n_row_store #(
    .WIDTH      (WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE),
    .CHUNK_SIZE (CHUNK_SIZE),
    .COL        (COL),
    .NUM_CORES  (NUM_CORES)
  ) u_row_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_beat (beat_cnt_q),
    .wr_data (in_r2n_buffer),
    .rd_row  (row_cnt_q),
    .rd_data (rd_data)
  );

  // Next state, counter updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    row_cnt_d    = row_cnt_q;
    grp_cnt_d    = grp_cnt_q;
    frame_done_d = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        row_cnt_d  = '0;
        grp_cnt_d  = '0;
        if (en) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready = en;
        if (in_valid && en) begin
          wr_en = 1'b1;
          if (beat_cnt_q == BEAT_LAST) begin
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d = '0;
            if (grp_cnt_q == GRP_LAST) begin
              grp_cnt_d    = '0;
              frame_done_d = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              grp_cnt_d = grp_cnt_q + 1'b1;
              state_d   = ST_FILL;
            end
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state register; reset abandons any partial group or frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      beat_cnt_q   <= '0;
      row_cnt_q    <= '0;
      grp_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      row_cnt_q    <= row_cnt_d;
      grp_cnt_q    <= grp_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_r2n_buffer = out_valid ? rd_data : '0;
  assign frame_done     = frame_done_q;

endmodule
